rom_stream_reader: RTL and testbench

Read-side initiator for the team's 8x4 single-port synchronous ROM. On a start pulse it walks a contiguous address window, with wrap-around, absorbs the ROM's one-cycle registered read latency, and presents each word on a valid/ready output stream that supports backpressure. It sits between the ROM and any downstream consumer, such as a display driver or pattern generator.

---
 rtl/rom_stream_pkg.sv | 22 ++
 rtl/stream_fifo2.sv | 59 +++++
 rtl/rom_stream_reader.sv | 145 ++++++++++++++
 tb/tb_rom_stream_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_pkg.sv
// ---------------------------------------------------------------------------
// rom_stream_pkg
// Shared definitions for the ROM stream reader slice:
//   - StateT      : reader control states
//   - DEF_ADDR_W  : default ROM address width (8-deep ROM)
//   - DEF_DATA_W  : default ROM word width
//   - FIFO_DEPTH  : depth of the output skid FIFO
// ---------------------------------------------------------------------------
package rom_stream_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 4;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } StateT;

endpackage

// File: rtl/stream_fifo2.sv
// ---------------------------------------------------------------------------
// stream_fifo2
// Two-entry synchronous FIFO used as the output buffer of the ROM stream
// reader. Each entry carries {last, data}. Push and pop may happen in the
// same cycle; the head entry is presented combinationally.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, empties the FIFO
//   push   in   write wrData into the tail
//   pop    in   drop the head entry (caller only pops when count != 0)
//   wrData in   entry to write
//   count  out  number of stored entries, 0..2
//   head   out  oldest stored entry
// ---------------------------------------------------------------------------
module stream_fifo2
    import rom_stream_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic             r_rdPtr;
    logic             r_wrPtr;
    logic [1:0]       r_count;

    // Storage and pointers. With only two slots the pointers are single bits
    // that simply flip on each push/pop. A simultaneous push and pop keeps
    // the count unchanged while both pointers advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wrPtr] <= wrData;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + 2'(push) - 2'(pop);
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rdPtr];

endmodule

// File: rtl/rom_stream_reader.sv
// ---------------------------------------------------------------------------
// rom_stream_reader
// Read-side initiator for the single-port synchronous ROM. A start pulse in
// IDLE walks len words beginning at start_addr (wrapping modulo the ROM
// depth), absorbs the ROM's one-cycle read latency and delivers every word
// on a valid/ready stream with backpressure.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle request, honoured only in IDLE
//   start_addr, len     first address and word count (0..2^ADDR_W)
//   busy                high in RUN and DRAIN
//   done                one-cycle completion pulse
//   rom_en, rom_addr    ROM read strobe and address
//   rom_data            ROM word, valid the cycle after rom_en
//   m_valid, m_ready    output stream handshake
//   m_data, m_last      output word and end-of-transfer marker
// ---------------------------------------------------------------------------
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    StateT             r_state;
    StateT             w_nextState;
    logic [ADDR_W-1:0] r_nextAddr;
    logic [ADDR_W:0]   r_issueLeft;
    logic              r_inflight;
    logic              r_inflightLast;
    logic [1:0]        w_count;
    logic [DATA_W:0]   w_head;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_lastIssue;
    logic              w_accept;

    assign m_valid = (w_count != 2'd0);
    assign m_data  = w_head[DATA_W-1:0];
    assign m_last  = m_valid & w_head[DATA_W];
    assign w_pop   = m_valid & m_ready;

    // Words buffered or on their way from the ROM, net of the one leaving
    // this cycle. Keeping this below the FIFO depth means the capture a
    // cycle after the issue always finds a free slot.
    assign w_occ       = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == RUN) && (r_issueLeft != '0) && (w_occ < 3'(FIFO_DEPTH));
    assign w_lastIssue = w_issue && (r_issueLeft == (ADDR_W+1)'(1));
    assign w_accept    = (r_state == IDLE) && start && (len != '0);
    assign rom_addr    = r_nextAddr;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control outputs. DRAIN waits until nothing is in flight
    // and the FIFO empties this cycle, so done lands right after the last beat.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        rom_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = (len != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                rom_en = w_issue;
                if (w_lastIssue) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!r_inflight && (w_occ == 3'd0)) begin
                    w_nextState = FIN;
                end
            end
            FIN: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Address/length counters and the in-flight flag. The flag follows each
    // issue by one cycle, matching the ROM latency, and carries the last tag
    // along with it so the final word is marked when it is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nextAddr     <= '0;
            r_issueLeft    <= '0;
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
        end else begin
            r_inflight     <= w_issue;
            r_inflightLast <= w_lastIssue;
            if (w_accept) begin
                r_nextAddr  <= start_addr;
                r_issueLeft <= len;
            end else if (w_issue) begin
                r_nextAddr  <= r_nextAddr + ADDR_W'(1);
                r_issueLeft <= r_issueLeft - (ADDR_W+1)'(1);
            end
        end
    end

    stream_fifo2 #(
        .WIDTH(DATA_W + 1)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_inflight),
        .pop   (w_pop),
        .wrData({r_inflightLast, rom_data}),
        .count (w_count),
        .head  (w_head)
    );

endmodule

// File: tb/tb_rom_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_stream_reader
// Scoreboard bench for rom_stream_reader. Stimulus pushes hand-computed
// expected beats; a negedge monitor pops and compares on every handshake and
// also watches stall stability, issue occupancy, ROM addresses and done.
// ---------------------------------------------------------------------------
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] start_addr;
    logic [3:0] len;
    logic       busy;
    logic       done;
    logic       rom_en;
    logic [2:0] rom_addr;
    logic [3:0] rom_data = 4'h0;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_data;
    logic       m_last;

    logic [3:0] romMem [8] = '{4'h1, 4'h3, 4'hA, 4'h6, 4'h7, 4'hD, 4'h9, 4'hB};

    int nCompared = 0;
    int nMismatched = 0;
    int cyc = 0;
    int startCyc = 0;
    int doneCyc = -1;
    int firstBeatCyc = -1;
    int lastBeatCyc = -1;
    int doneCount = 0;
    int issuedCnt = 0;
    int acceptedCnt = 0;
    int issuedAtStart = 0;
    int acceptedAtStart = 0;
    bit doneSeen = 1'b0;
    bit sawValid = 1'b0;
    bit prevStall = 1'b0;
    logic [3:0] prevData = 4'h0;
    logic [4:0] sb [$];
    logic [2:0] addrLog [$];

    rom_stream_reader #(.ADDR_W(3), .DATA_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model with one-cycle registered read.
    always @(posedge clk) begin
        if (rom_en) rom_data <= romMem[rom_addr];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: everything is sampled on the falling edge, halfway between
    // the edges at which the DUT and the stimulus change.
    always @(negedge clk) begin
        logic [4:0] expBeat;
        if (rst) begin
            prevStall   = 1'b0;
            issuedCnt   = 0;
            acceptedCnt = 0;
        end else begin
            if (prevStall) begin
                checkOutput("stall valid held", int'(m_valid), 1);
                checkOutput("stall data held", int'(m_data), int'(prevData));
            end
            if (rom_en) begin
                checkOutput("issue with room", int'((issuedCnt - acceptedCnt - int'(m_valid && m_ready)) < 2), 1);
                issuedCnt++;
                addrLog.push_back(rom_addr);
            end
            if (m_valid) sawValid = 1'b1;
            if (m_valid && m_ready) begin
                checkOutput("beat expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    expBeat = sb.pop_front();
                    checkOutput("beat data", int'(m_data), int'(expBeat[3:0]));
                    checkOutput("beat last", int'(m_last), int'(expBeat[4]));
                end
                if (firstBeatCyc < 0) firstBeatCyc = cyc - startCyc;
                lastBeatCyc = cyc - startCyc;
                acceptedCnt++;
            end
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
            if (done) begin
                doneSeen = 1'b1;
                doneCount++;
                doneCyc = cyc - startCyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse and queue the expected beats; expNib holds the
    // expected words most-significant nibble first.
    task automatic applyStimulus(input logic [2:0] addr, input logic [3:0] n, input logic [31:0] expNib);
        start_addr      = addr;
        len             = n;
        start           = 1'b1;
        startCyc        = cyc;
        doneSeen        = 1'b0;
        doneCyc         = -1;
        firstBeatCyc    = -1;
        lastBeatCyc     = -1;
        sawValid        = 1'b0;
        issuedAtStart   = issuedCnt;
        acceptedAtStart = acceptedCnt;
        addrLog.delete();
        for (int i = 0; i < int'(n); i++) begin
            sb.push_back({(i == int'(n) - 1), expNib[31-4*i -: 4]});
        end
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input bit toggle);
        for (int k = 0; k < 100 && !doneSeen; k++) begin
            tick();
            if (toggle) m_ready = ~m_ready;
        end
        checkOutput("done before timeout", int'(doneSeen), 1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " done"}, int'(done), 0);
        checkOutput({tag, " rom_en"}, int'(rom_en), 0);
        checkOutput({tag, " rom_addr"}, int'(rom_addr), 0);
        checkOutput({tag, " m_valid"}, int'(m_valid), 0);
        checkOutput({tag, " m_data"}, int'(m_data), 0);
        checkOutput({tag, " m_last"}, int'(m_last), 0);
    endtask

    initial begin
        logic [2:0] expAddr [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
        int dc;

        rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkReset("reset");
        tick();

        // Full sweep, no backpressure.
        m_ready = 1'b1;
        applyStimulus(3'd0, 4'd8, 32'h13A67D9B);
        waitDone(1'b0);
        checkOutput("t1 first beat cycle", firstBeatCyc, 3);
        checkOutput("t1 last beat cycle", lastBeatCyc, 10);
        checkOutput("t1 done cycle", doneCyc, 11);
        checkOutput("t1 reads issued", addrLog.size(), 8);
        checkOutput("t1 beats left", sb.size(), 0);

        // Wrap-around window.
        applyStimulus(3'd6, 4'd4, 32'h9B130000);
        waitDone(1'b0);
        checkOutput("t2 done cycle", doneCyc, 7);
        checkOutput("t2 reads issued", addrLog.size(), 4);
        for (int i = 0; i < 4 && i < addrLog.size(); i++) begin
            checkOutput("t2 rom_addr", int'(addrLog[i]), int'(expAddr[i]));
        end
        checkOutput("t2 beats left", sb.size(), 0);

        // Alternating backpressure.
        applyStimulus(3'd2, 4'd5, 32'hA67D9000);
        waitDone(1'b1);
        m_ready = 1'b1;
        checkOutput("t3 reads issued", addrLog.size(), 5);
        checkOutput("t3 beats left", sb.size(), 0);

        // Long stall right after start.
        m_ready = 1'b0;
        applyStimulus(3'd0, 4'd8, 32'h13A67D9B);
        repeat (9) tick();
        @(negedge clk);
        checkOutput("t4 reads while stalled", issuedCnt - issuedAtStart, 2);
        checkOutput("t4 m_valid while stalled", int'(m_valid), 1);
        checkOutput("t4 m_data while stalled", int'(m_data), 1);
        tick();
        m_ready = 1'b1;
        waitDone(1'b0);
        checkOutput("t4 reads total", issuedCnt - issuedAtStart, 8);
        checkOutput("t4 beats left", sb.size(), 0);

        // Zero-length transfer.
        applyStimulus(3'd3, 4'd0, 32'h0);
        waitDone(1'b0);
        checkOutput("t5 len0 done cycle", doneCyc, 1);
        checkOutput("t5 len0 reads", issuedCnt - issuedAtStart, 0);
        checkOutput("t5 len0 valid seen", int'(sawValid), 0);

        // Start while busy is ignored.
        dc = doneCount;
        applyStimulus(3'd0, 4'd3, 32'h13A00000);
        tick();
        checkOutput("t5 busy at second start", int'(busy), 1);
        start_addr = 3'd5;
        len        = 4'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        waitDone(1'b0);
        repeat (5) tick();
        checkOutput("t5 done pulses", doneCount - dc, 1);
        checkOutput("t5 reads", issuedCnt - issuedAtStart, 3);
        checkOutput("t5 beats left", sb.size(), 0);

        // Reset while the third beat is stalled.
        applyStimulus(3'd0, 4'd8, 32'h13A67D9B);
        for (int k = 0; k < 50 && (acceptedCnt - acceptedAtStart) < 2; k++) tick();
        checkOutput("t6 beats before stall", acceptedCnt - acceptedAtStart, 2);
        m_ready = 1'b0;
        tick();
        tick();
        checkOutput("t6 stalled valid", int'(m_valid), 1);
        checkOutput("t6 stalled data", int'(m_data), 'hA);
        dc  = doneCount;
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkReset("abort");
        sawValid = 1'b0;
        tick();
        repeat (10) tick();
        checkOutput("t6 no done after abort", doneCount - dc, 0);
        checkOutput("t6 no valid after abort", int'(sawValid), 0);
        m_ready = 1'b1;
        applyStimulus(3'd0, 4'd2, 32'h13000000);
        waitDone(1'b0);
        repeat (3) tick();
        checkOutput("t6 restart done cycle", doneCyc, 5);
        checkOutput("t6 restart beats left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
